// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle registered read)
// between the instruction-fetch port and the data load/store port.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  busy,
    output logic                  grant
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                  ram_we_q, ram_we_d;
    logic                  i_ack_q, i_ack_d;
    logic                  d_ack_q, d_ack_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  i_elig, d_elig, pick_d;

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            grant_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state: a port still seeing its own ack is not eligible again yet
    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = 1'b0;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        grant_d    = grant_q;
        i_elig     = i_req & ~i_ack_q;
        d_elig     = d_req & ~d_ack_q;
        pick_d     = (i_elig & d_elig) ? ~grant_q : d_elig;

        unique case (state_q)
            ST_IDLE: begin
                if (i_elig | d_elig) begin
                    grant_d    = pick_d;
                    ram_addr_d = pick_d ? d_addr : i_addr;
                    ram_data_d = pick_d ? d_wdata : ram_data_q;
                    ram_we_d   = pick_d & d_we;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (ram_we_q) begin
                    d_ack_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (grant_q) begin
                    d_rdata_d = ram_q;
                    d_ack_d   = 1'b1;
                end else begin
                    i_rdata_d = ram_q;
                    i_ack_d   = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign i_ack    = i_ack_q;
    assign d_ack    = d_ack_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ram_we   = ram_we_q;
    assign grant    = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM, transaction-schedule reference
// model compared every cycle, plus directed literal expectations.
module tb_mem_port_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_ack, d_ack, ram_we, busy, grant;
    logic [DW-1:0] i_rdata, d_rdata, ram_data, ram_q;
    logic [AW-1:0] ram_addr;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
        .busy(busy), .grant(grant)
    );

    // Behavioural single-port RAM with registered read address
    logic          pl_en = 1'b0;
    logic [5:0]    pl_idx;
    logic [DW-1:0] pl_val;
    logic [DW-1:0] ram_mem [64];
    logic [AW-1:0] ram_addr_r;
    always @(posedge clk) begin
        if (pl_en) ram_mem[pl_idx] <= pl_val;
        else if (ram_we) ram_mem[ram_addr[7:2]] <= ram_data;
        ram_addr_r <= ram_addr;
    end
    assign ram_q = ram_mem[ram_addr_r[7:2]];

    // Reference model: an access occupies a fixed number of cycles after its grant
    logic [DW-1:0] mdl_mem [64];
    logic          m_i_ack, m_d_ack, m_ram_we, m_busy, m_grant, m_op_we;
    logic [DW-1:0] m_i_rdata, m_d_rdata, m_ram_data;
    logic [AW-1:0] m_ram_addr;
    int            m_rem;
    logic          m_ie, m_de, m_pick;
    always @(posedge clk or negedge reset) begin
        if (pl_en) mdl_mem[pl_idx] = pl_val;
        if (!reset) begin
            m_i_ack = 0; m_d_ack = 0; m_ram_we = 0; m_busy = 0; m_grant = 1;
            m_i_rdata = '0; m_d_rdata = '0; m_ram_data = '0; m_ram_addr = '0;
            m_rem = 0; m_op_we = 0;
        end else begin
            m_ie = i_req && !m_i_ack;
            m_de = d_req && !m_d_ack;
            m_i_ack = 0; m_d_ack = 0; m_ram_we = 0;
            if (m_rem == 0) begin
                if (m_ie || m_de) begin
                    m_pick     = (m_ie && m_de) ? !m_grant : m_de;
                    m_grant    = m_pick;
                    m_op_we    = m_pick && d_we;
                    m_ram_addr = m_pick ? d_addr : i_addr;
                    if (m_pick) m_ram_data = d_wdata;
                    m_ram_we   = m_op_we;
                    m_rem      = m_op_we ? 1 : 2;
                end
            end else begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    if (m_op_we) begin
                        mdl_mem[m_ram_addr[7:2]] = m_ram_data;
                        m_d_ack = 1;
                    end else if (m_grant) begin
                        m_d_rdata = mdl_mem[m_ram_addr[7:2]];
                        m_d_ack = 1;
                    end else begin
                        m_i_rdata = mdl_mem[m_ram_addr[7:2]];
                        m_i_ack = 1;
                    end
                end
            end
            m_busy = (m_rem != 0);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare plus event monitors
    logic chk_en = 1'b0;
    logic prev_busy = 1'b0;
    int   n_acc = 0, n_iack = 0, n_dack = 0, n_we = 0;
    int   ack_order[$];
    always @(negedge clk) begin
        if (chk_en) begin
            check("i_ack", 32'(i_ack), 32'(m_i_ack));
            check("d_ack", 32'(d_ack), 32'(m_d_ack));
            check("i_rdata", i_rdata, m_i_rdata);
            check("d_rdata", d_rdata, m_d_rdata);
            check("ram_we", 32'(ram_we), 32'(m_ram_we));
            check("ram_addr", ram_addr, m_ram_addr);
            check("ram_data", ram_data, m_ram_data);
            check("busy", 32'(busy), 32'(m_busy));
            check("grant", 32'(grant), 32'(m_grant));
        end
        if (busy && !prev_busy) n_acc++;
        prev_busy = busy;
        if (ram_we) n_we++;
        if (i_ack) begin n_iack++; ack_order.push_back(0); end
        if (d_ack) begin n_dack++; ack_order.push_back(1); end
    end

    // Caller is at posedge+2; holds req through the ack cycle, drops it after
    task automatic access(input logic is_d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd);
        logic ackv;
        if (is_d) begin d_we = we; d_addr = addr; d_wdata = wd; d_req = 1; end
        else begin i_addr = addr; i_req = 1; end
        lat = 0; rd = '0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            ackv = is_d ? d_ack : i_ack;
            if (ackv) begin rd = is_d ? d_rdata : i_rdata; break; end
            if (lat > 20) begin check("ack_wait", 32'(ackv), 32'd1); break; end
        end
        @(posedge clk); #2;
        if (is_d) d_req = 0; else i_req = 0;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] v);
        @(posedge clk); #2;
        pl_en = 1; pl_idx = addr[7:2]; pl_val = v;
        @(posedge clk); #2;
        pl_en = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int lat, base_acc, base_d, base_we, wait_cyc;
        logic [31:0] rd;
        reset = 0; i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        preload(32'h10, 32'hDEADBEEF);
        preload(32'h30, 32'hA5A5A5A5);
        preload(32'h40, 32'h00001111);
        preload(32'h44, 32'h00002222);
        chk_en = 1;

        // Reset held with both requests high
        i_addr = 32'h40; d_addr = 32'h44; d_we = 0; i_req = 1; d_req = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_i_ack", 32'(i_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_data", ram_data, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd1);
        #1 reset = 1;

        // Contention from reset release: I first, then strict alternation
        ack_order.delete();
        @(posedge clk); #1;
        check("first_grant", 32'(grant), 32'd0);
        check("first_busy", 32'(busy), 32'd1);
        wait_cyc = 0;
        while (ack_order.size() < 4 && wait_cyc < 40) begin
            @(posedge clk); #1; wait_cyc++;
        end
        check("contend_acks", 32'(ack_order.size() >= 4), 32'd1);
        #1 i_req = 0; d_req = 0;
        repeat (6) @(posedge clk);
        #2;
        if (ack_order.size() >= 4) begin
            check("order0", 32'(ack_order[0]), 32'd0);
            check("order1", 32'(ack_order[1]), 32'd1);
            check("order2", 32'(ack_order[2]), 32'd0);
            check("order3", 32'(ack_order[3]), 32'd1);
        end
        check("contend_i_rdata", i_rdata, 32'h00001111);
        check("contend_d_rdata", d_rdata, 32'h00002222);

        // I read only
        base_acc = n_acc; base_d = n_dack;
        access(0, 0, 32'h10, 32'h0, lat, rd);
        check("i_lat", 32'(lat), 32'd3);
        check("i_data", rd, 32'hDEADBEEF);
        repeat (3) @(posedge clk);
        #2;
        check("i_only_dack", 32'(n_dack - base_d), 32'd0);
        check("i_one_access", 32'(n_acc - base_acc), 32'd1);

        // D write then read back
        base_we = n_we; base_acc = n_acc;
        access(1, 1, 32'h24, 32'h12345678, lat, rd);
        check("w_lat", 32'(lat), 32'd2);
        check("w_we_cycles", 32'(n_we - base_we), 32'd1);
        access(1, 0, 32'h24, 32'h0, lat, rd);
        check("r_lat", 32'(lat), 32'd3);
        check("r_data", rd, 32'h12345678);
        check("i_rdata_kept", i_rdata, 32'hDEADBEEF);
        repeat (2) @(posedge clk);
        #2;
        check("wr_two_access", 32'(n_acc - base_acc), 32'd2);

        // Async reset during a write's ACCESS cycle
        base_d = n_dack;
        d_we = 1; d_addr = 32'h30; d_wdata = 32'h11111111; d_req = 1;
        @(posedge clk); #2;
        check("pre_rst_we", 32'(ram_we), 32'd1);
        #1 reset = 0;
        #1;
        check("abort_we", 32'(ram_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_grant", 32'(grant), 32'd1);
        d_req = 0; d_we = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1;
        repeat (4) @(posedge clk);
        #2;
        check("abort_no_dack", 32'(n_dack - base_d), 32'd0);
        check("abort_ram", ram_mem[12], 32'hA5A5A5A5);
        access(1, 0, 32'h30, 32'h0, lat, rd);
        check("post_rst_data", rd, 32'hA5A5A5A5);
        repeat (3) @(posedge clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
